// File: rtl/controlador_elevador_2p_pkg.sv
// Shared definitions for the two-floor elevator controller: state
// encodings, floor indices and the floor-to-request-bit mapping.
package controlador_elevador_2p_pkg;

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        SUBIENDO = 2'd1,
        BAJANDO  = 2'd2,
        PUERTA   = 2'd3
    } estado_t;

    localparam logic PISO_0 = 1'b0;
    localparam logic PISO_1 = 1'b1;

    // Request-word bit that belongs to a given floor.
    function automatic logic [1:0] onehot_piso(input logic piso);
        return (piso == PISO_1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/controlador_elevador_2p_temporizador_carga.sv
// Loadable down-counter shared by the travel and door phases.
// Loading takes priority; otherwise it counts down and parks at zero.
module controlador_elevador_2p_temporizador_carga #(
    parameter int ANCHO = 4
) (
    input  logic             _clk_,
    input  logic             _reset_,
    input  logic             cargar,
    input  logic [ANCHO-1:0] valor,
    output logic             cero
);

    logic [ANCHO-1:0] cuenta;

    // Load a new interval or count down toward zero
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge _clk_ or posedge _reset_) begin
        if (_reset_) begin
            cuenta <= '0;
        end else if (cargar) begin
            cuenta <= valor;
        end else if (cuenta != '0) begin
            cuenta <= cuenta - ANCHO'(1);
        end
    end

    assign cero = (cuenta == '0);

endmodule

// File: rtl/controlador_elevador_2p.sv
// Two-floor elevator controller. Serves the sticky request word, pulses
// the register clear on the first door cycle and keeps a pending bit so
// the other floor's call survives the register's whole-word clear.
module controlador_elevador_2p
    import controlador_elevador_2p_pkg::*;
#(
    parameter int T_VIAJE  = 8,
    parameter int T_PUERTA = 4
) (
    input  logic       _clk_,
    input  logic       _reset_,
    input  logic [1:0] solicitudes_i,
    output logic       limpiar_o,
    output logic       motor_subir_o,
    output logic       motor_bajar_o,
    output logic       puerta_abierta_o,
    output logic       piso_o
);

    localparam int T_MAX = (T_VIAJE > T_PUERTA) ? T_VIAJE : T_PUERTA;
    localparam int ANCHO = $clog2(T_MAX + 1);
    localparam logic [ANCHO-1:0] CARGA_VIAJE  = ANCHO'(T_VIAJE - 1);
    localparam logic [ANCHO-1:0] CARGA_PUERTA = ANCHO'(T_PUERTA - 1);

    estado_t          estado;
    logic [1:0]       pendiente;
    logic [1:0]       req;
    logic             propio;
    logic             otro;
    logic             tmr_cargar;
    logic [ANCHO-1:0] tmr_valor;
    logic             tmr_cero;

    assign req    = solicitudes_i | pendiente;
    assign propio = req[piso_o];
    assign otro   = req[~piso_o];

    // Timer load: entering travel loads the trip time, entering the door loads the door time
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        tmr_cargar = 1'b0;
        tmr_valor  = CARGA_PUERTA;
        case (estado)
            REPOSO: begin
                if (propio) begin
                    tmr_cargar = 1'b1;
                end else if (otro) begin
                    tmr_cargar = 1'b1;
                    tmr_valor  = CARGA_VIAJE;
                end
            end
            SUBIENDO, BAJANDO: tmr_cargar = tmr_cero;
            default: ;
        endcase
    end

    controlador_elevador_2p_temporizador_carga #(
        .ANCHO (ANCHO)
    ) u_temporizador_carga (
        ._clk_   (_clk_),
        ._reset_ (_reset_),
        .cargar  (tmr_cargar),
        .valor   (tmr_valor),
        .cero    (tmr_cero)
    );

    // State, floor, pending calls and all registered outputs advance together
    always_ff @(posedge _clk_ or posedge _reset_) begin
        if (_reset_) begin
            estado           <= REPOSO;
            piso_o           <= PISO_0;
            pendiente        <= 2'b00;
            limpiar_o        <= 1'b0;
            motor_subir_o    <= 1'b0;
            motor_bajar_o    <= 1'b0;
            puerta_abierta_o <= 1'b0;
        end else begin
            limpiar_o <= 1'b0;
            case (estado)
                REPOSO: begin
                    // Own-floor call wins over a call for the other floor.
                    if (propio) begin
                        estado           <= PUERTA;
                        puerta_abierta_o <= 1'b1;
                        limpiar_o        <= 1'b1;
                    end else if (otro) begin
                        if (piso_o == PISO_0) begin
                            estado        <= SUBIENDO;
                            motor_subir_o <= 1'b1;
                        end else begin
                            estado        <= BAJANDO;
                            motor_bajar_o <= 1'b1;
                        end
                    end
                end
                SUBIENDO, BAJANDO: begin
                    if (tmr_cero) begin
                        estado           <= PUERTA;
                        motor_subir_o    <= 1'b0;
                        motor_bajar_o    <= 1'b0;
                        puerta_abierta_o <= 1'b1;
                        limpiar_o        <= 1'b1;
                        piso_o           <= (piso_o == PISO_0) ? PISO_1 : PISO_0;
                    end
                end
                PUERTA: begin
                    // limpiar_o is high only in the first door cycle, while the
                    // register still shows the calls it is about to drop.
                    if (limpiar_o) begin
                        pendiente <= req & ~onehot_piso(piso_o);
                    end
                    if (tmr_cero) begin
                        estado           <= REPOSO;
                        puerta_abierta_o <= 1'b0;
                    end
                end
                default: estado <= REPOSO;
            endcase
        end
    end

endmodule

// File: doc/controlador_elevador_2p.md
# controlador_elevador_2p

Two-floor elevator control FSM that consumes the sticky call-request word produced by the 2-bit request register and drives motor, door and floor-position outputs. It issues the one-cycle clear pulse back to that register when a floor is served, and keeps an internal pending bit so a call for the other floor is not lost by the register's whole-word clear. It sits directly downstream of the request register and upstream of the motor/door drivers and floor display.

## Interface
Parameters:
- `T_VIAJE`, 8, travel time between floors in clock cycles (≥1)
- `T_PUERTA`, 4, door-open time in clock cycles (≥1)

Ports:
- `_clk_` in 1: single system clock, all state on rising edge
- `_reset_` in 1: reset, asynchronous, active-high
- `solicitudes_i` in 2: registered call requests; bit0 = floor 0, bit1 = floor 1
- `limpiar_o` out 1: clear pulse to the request register
- `motor_subir_o` out 1: motor up command
- `motor_bajar_o` out 1: motor down command
- `puerta_abierta_o` out 1: door open command
- `piso_o` out 1: current floor (0/1)

## Operation
- All outputs are registered. On `_reset_`: state REPOSO, `piso_o`=0, every output 0, timer 0, `pendiente`=2'b00.
- `req` = `solicitudes_i` | `pendiente`. `propio` = `req[piso]`, `otro` = `req[~piso]`.
- States:
  - REPOSO: if `propio` → PUERTA. Else if `otro`: go to SUBIENDO if `piso`=0, or BAJANDO if `piso`=1; load timer = `T_VIAJE`-1. Otherwise stay. `propio` has priority over `otro`.
  - SUBIENDO / BAJANDO: `motor_subir_o` / `motor_bajar_o` high. Timer decrements each cycle. In the cycle the timer reads 0: toggle `piso`, go to PUERTA.
  - PUERTA: `puerta_abierta_o` high. Entry loads timer = `T_PUERTA`-1. In the cycle the timer reads 0 → REPOSO.
- On the first cycle of PUERTA:
  - `limpiar_o`=1.
  - Capture `pendiente` <= `req` & ~onehot(`piso`). The served floor's call is dropped; the other floor's call is kept.
- `limpiar_o` is 0 in every other cycle.
- `motor_subir_o` and `motor_bajar_o` are never high together. No motor output is high while `puerta_abierta_o` is high.
- A call for the current floor arriving during PUERTA is not merged into the open-door period. On return to REPOSO, `propio` is seen and the door reopens.
- A button edge presented to the register in the same cycle as `limpiar_o` is dropped, because the register's clear has priority. This is accepted, since buttons are held for many cycles.
- Timer width = $clog2(max(`T_VIAJE`,`T_PUERTA`)+1).

## Timing
- Call seen in REPOSO at cycle n → transition output (motor or door) high from cycle n+1.
- Motor output is high for exactly `T_VIAJE` cycles.
- `piso_o` updates on the same edge that raises `puerta_abierta_o`.
- Door is high for exactly `T_PUERTA` cycles. REPOSO lasts at least 1 cycle between consecutive door/travel periods.
- `limpiar_o` is coincident with the first door cycle. The register output reads 0 from the following cycle.
- Asynchronous reset mid-travel or mid-door forces all outputs to 0 immediately. `piso_o` returns to 0 whatever the physical position was; recalibration is outside this block.

## Structure
- Shared include header holds the state encodings (REPOSO, SUBIENDO, BAJANDO, PUERTA as 2-bit localparams) and the floor-index constants. The top-level controller and bench reuse these.
- One sub-module is natural: `temporizador_carga`.
  - Loadable down-counter, parameterised width.
  - Inputs: `cargar`, `valor`. Output: `cero`.
  - Shared by the travel and door phases.

## Test plan
- Reset: assert `_reset_` asynchronously mid-cycle → all outputs 0 at once, `piso_o`=0; after release, stays in REPOSO with `solicitudes_i`=00.
- Up trip (defaults), `solicitudes_i`=10 at cycle 0:
  - `motor_subir_o` high cycles 1–8.
  - Cycle 9: `piso_o`=1, `puerta_abierta_o` high cycles 9–12, `limpiar_o` high only in cycle 9.
  - REPOSO at cycle 13.
- Same-floor call: at floor 0, `solicitudes_i`=01 → door high cycles 1–4, `limpiar_o` at cycle 1, no motor activity.
- Both calls: at floor 0, `solicitudes_i`=11 →
  - Door opens first; `pendiente`=10 captured while the register clears to 00.
  - After door plus one REPOSO cycle, `motor_subir_o` high for 8 cycles.
  - Arrival at floor 1 clears `pendiente`.
- Reset mid-travel: assert `_reset_` in travel cycle 4 of a down trip → `motor_bajar_o` drops immediately, `piso_o`=0, no `limpiar_o` pulse.
- Reopen: at floor 1, call 10 is re-asserted during PUERTA → door closes after `T_PUERTA`, 1 REPOSO cycle, then door reopens with a second `limpiar_o` pulse.
